// File: rtl/bit_selection_stream_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : bit_selection_stream_pkg
// Brief   : Shared encodings and helpers for the bit-selection stream block.
// Rev     : 1.0 - initial release
// ---------------------------------------------------------------------------
package bit_selection_stream_pkg;

   localparam logic c_mode_trunc = 1'b0;
   localparam logic c_mode_rot   = 1'b1;
   localparam logic c_dummy_bit  = 1'b0;

   function automatic int calc_cmd_width(input int data_width);
      return $clog2(data_width);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bit_selection_stream_shift_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : bit_selection_stream_shift_stage
// Brief   : One registered shift/rotate-right stage (amount * SHIFT_STEP).
// Rev     : 1.0 - initial release
// ---------------------------------------------------------------------------
module bit_selection_stream_shift_stage
   import bit_selection_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int OUT_WIDTH  = DATA_WIDTH,
   parameter int SHIFT_STEP = 1,
   parameter int AMT_WIDTH  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_flush,
   input  logic                  i_load,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic [AMT_WIDTH-1:0]  i_amt,
   input  logic                  i_mode,
   input  logic                  i_en,
   output logic                  o_valid,
   output logic [OUT_WIDTH-1:0]  o_data
);

   logic [DATA_WIDTH-1:0] w_upper;
   logic [31:0]           w_sh;
   logic                  r_valid;
   logic [OUT_WIDTH-1:0]  r_data;

   // Rotation feeds the word back in above itself; truncation feeds zeros.
   always_comb begin
      w_upper = i_data;
      if (i_mode == c_mode_trunc) w_upper = '0;
   end

   assign w_sh = 32'(i_amt) * 32'(SHIFT_STEP);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         if (i_flush)     r_valid <= 1'b0;
         else if (i_load) r_valid <= i_valid;
         if (i_load && i_valid)
            r_data <= i_en ? OUT_WIDTH'({w_upper, i_data} >> w_sh) : {OUT_WIDTH{c_dummy_bit}};
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/bit_selection_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : bit_selection_stream
// Brief   : Two-stage pipelined field extractor with valid/ready and flush.
// Rev     : 1.0 - initial release
// ---------------------------------------------------------------------------
module bit_selection_stream
   import bit_selection_stream_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int OUT_WIDTH     = DATA_WIDTH / 2,
   parameter int COMMAND_WIDTH = calc_cmd_width(DATA_WIDTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_valid,
   output logic                     i_ready,
   input  logic [DATA_WIDTH-1:0]    i_data_bus,
   input  logic [COMMAND_WIDTH-1:0] i_cmd,
   input  logic                     i_mode,
   input  logic                     i_en,
   input  logic                     i_flush,
   output logic                     o_valid,
   input  logic                     o_ready,
   output logic [OUT_WIDTH-1:0]     o_data_bus,
   output logic                     o_busy
);

   localparam int c_lo_w = COMMAND_WIDTH / 2;
   localparam int c_hi_w = COMMAND_WIDTH - c_lo_w;

   logic                  w_s1_valid;
   logic [DATA_WIDTH-1:0] w_s1_data;
   logic                  w_s1_load;
   logic                  w_s2_load;
   logic                  w_in_hs;
   logic [c_lo_w-1:0]     r_s1_lo;
   logic                  r_s1_mode;
   logic                  r_s1_en;

   assign w_s2_load = ~o_valid | o_ready;
   assign w_s1_load = ~w_s1_valid | w_s2_load;
   assign i_ready   = w_s1_load & ~i_flush;
   assign w_in_hs   = i_valid & i_ready;
   assign o_busy    = w_s1_valid | o_valid;

   // Coarse stage moves by whole multiples of 2**c_lo_w; enable is applied later.
   bit_selection_stream_shift_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .OUT_WIDTH  (DATA_WIDTH),
      .SHIFT_STEP (1 << c_lo_w),
      .AMT_WIDTH  (c_hi_w)
   ) u_coarse (
      .clk     (clk),
      .rst     (rst),
      .i_flush (i_flush),
      .i_load  (w_s1_load),
      .i_valid (w_in_hs),
      .i_data  (i_data_bus),
      .i_amt   (i_cmd[COMMAND_WIDTH-1:c_lo_w]),
      .i_mode  (i_mode),
      .i_en    (1'b1),
      .o_valid (w_s1_valid),
      .o_data  (w_s1_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1_lo   <= '0;
         r_s1_mode <= c_mode_trunc;
         r_s1_en   <= 1'b0;
      end else if (w_s1_load && w_in_hs) begin
         r_s1_lo   <= i_cmd[c_lo_w-1:0];
         r_s1_mode <= i_mode;
         r_s1_en   <= i_en;
      end
   end

   bit_selection_stream_shift_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH),
      .SHIFT_STEP (1),
      .AMT_WIDTH  (c_lo_w)
   ) u_fine (
      .clk     (clk),
      .rst     (rst),
      .i_flush (i_flush),
      .i_load  (w_s2_load),
      .i_valid (w_s1_valid),
      .i_data  (w_s1_data),
      .i_amt   (r_s1_lo),
      .i_mode  (r_s1_mode),
      .i_en    (r_s1_en),
      .o_valid (o_valid),
      .o_data  (o_data_bus)
   );

endmodule
`default_nettype wire

// File: tb/tb_bit_selection_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_bit_selection_stream
// Brief   : Self-checking bench: vector table, directed corners, random stream.
// Rev     : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_bit_selection_stream;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  cmd;
      logic        mode;
      logic        en;
      logic [15:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_valid = 1'b0;
   logic        i_ready;
   logic [31:0] i_data_bus = '0;
   logic [4:0]  i_cmd = '0;
   logic        i_mode = 1'b0;
   logic        i_en = 1'b0;
   logic        i_flush = 1'b0;
   logic        o_valid;
   logic        o_ready = 1'b0;
   logic [15:0] o_data_bus;
   logic        o_busy;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [15:0] sb[$];
   bit          last_acc;
   vec_t        tbl[10];
   vec_t        st[6];

   bit_selection_stream #(.DATA_WIDTH(32), .OUT_WIDTH(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_valid    (i_valid),
      .i_ready    (i_ready),
      .i_data_bus (i_data_bus),
      .i_cmd      (i_cmd),
      .i_mode     (i_mode),
      .i_en       (i_en),
      .i_flush    (i_flush),
      .o_valid    (o_valid),
      .o_ready    (o_ready),
      .o_data_bus (o_data_bus),
      .o_busy     (o_busy)
   );

   always #5 clk = ~clk;

   // Reference selection: plain shift/rotate arithmetic on the 32-bit word.
   function automatic logic [15:0] ref_sel(logic [31:0] d, logic [4:0] c, logic m, logic e);
      logic [31:0] r;
      if (!e) return 16'h0;
      if (m == 1'b0) r = d >> c;
      else if (c == 5'd0) r = d;
      else r = (d >> c) | (d << (6'd32 - {1'b0, c}));
      return r[15:0];
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(logic v, logic [31:0] d, logic [4:0] c, logic m, logic e);
      i_valid = v; i_data_bus = d; i_cmd = c; i_mode = m; i_en = e;
   endtask

   // Evaluate the handshakes that the coming posedge will perform, then advance.
   task automatic tick();
      #1;
      chk("busy_vs_inflight", {31'h0, o_busy}, {31'h0, sb.size() != 0});
      if (o_valid && o_ready) begin
         if (sb.size() == 0) chk("spurious_out", {31'h0, o_valid}, 32'h0);
         else chk("out_data", {16'h0, o_data_bus}, {16'h0, sb.pop_front()});
      end
      if (i_flush) begin
         chk("ready_in_flush", {31'h0, i_ready}, 32'h0);
         sb.delete();
      end
      last_acc = i_valid && i_ready;
      if (last_acc) sb.push_back(ref_sel(i_data_bus, i_cmd, i_mode, i_en));
      @(negedge clk);
   endtask

   initial begin
      logic [15:0] held;
      int          k;
      int          cyc;

      tbl[0] = '{32'hA4420810, 5'd0,  1'b0, 1'b1, 16'h0810};
      tbl[1] = '{32'hA4420810, 5'd4,  1'b0, 1'b1, 16'h2081};
      tbl[2] = '{32'hA4420810, 5'd16, 1'b0, 1'b1, 16'hA442};
      tbl[3] = '{32'hA4420810, 5'd20, 1'b0, 1'b1, 16'h0A44};
      tbl[4] = '{32'hA4420810, 5'd28, 1'b0, 1'b1, 16'h000A};
      tbl[5] = '{32'hA4420810, 5'd28, 1'b1, 1'b1, 16'h810A};
      tbl[6] = '{32'hA4420810, 5'd16, 1'b1, 1'b1, 16'hA442};
      tbl[7] = '{32'hA4420810, 5'd0,  1'b1, 1'b1, 16'h0810};
      tbl[8] = '{32'hA4420810, 5'd4,  1'b0, 1'b0, 16'h0000};
      tbl[9] = '{32'hA4420810, 5'd4,  1'b0, 1'b1, 16'h2081};

      // Reset state
      @(negedge clk); @(negedge clk);
      chk("rst_o_valid", {31'h0, o_valid}, 32'h0);
      chk("rst_o_busy",  {31'h0, o_busy}, 32'h0);
      chk("rst_o_data",  {16'h0, o_data_bus}, 32'h0);
      rst = 1'b1;
      #1 chk("rst_rel_ready", {31'h0, i_ready}, 32'h1);
      @(negedge clk);
      o_ready = 1'b1;

      // Table: one beat per cycle, each visible two cycles after acceptance
      for (int j = 0; j <= 10; j++) begin
         if (j < 10) drive(1'b1, tbl[j].data, tbl[j].cmd, tbl[j].mode, tbl[j].en);
         else drive(1'b0, '0, '0, 1'b0, 1'b0);
         tick();
         if (j >= 1) begin
            chk("tbl_valid", {31'h0, o_valid}, 32'h1);
            chk("tbl_data", {16'h0, o_data_bus}, {16'h0, tbl[j-1].exp});
         end
      end
      tick();

      // Stall: o_ready low for 4 cycles while streaming
      for (int j = 0; j < 6; j++)
         st[j] = '{$urandom, 5'($urandom), 1'($urandom), 1'b1, 16'h0};
      k = 0;
      held = '0;
      for (cyc = 0; cyc < 40 && (k < 6 || sb.size() != 0); cyc++) begin
         o_ready = (cyc >= 4);
         if (k < 6) drive(1'b1, st[k].data, st[k].cmd, st[k].mode, st[k].en);
         else drive(1'b0, '0, '0, 1'b0, 1'b0);
         #1;
         if (cyc == 2) begin
            chk("stall_accepted", k, 2);
            chk("stall_ready", {31'h0, i_ready}, 32'h0);
            chk("stall_valid", {31'h0, o_valid}, 32'h1);
            held = o_data_bus;
         end
         if (cyc == 3 || cyc == 4) begin
            chk("stall_hold_data", {16'h0, o_data_bus}, {16'h0, held});
            chk("stall_hold_valid", {31'h0, o_valid}, 32'h1);
         end
         if (cyc == 3) chk("stall_ready", {31'h0, i_ready}, 32'h0);
         tick();
         if (last_acc) k++;
      end
      chk("stall_all_sent", k, 6);
      chk("stall_all_drained", sb.size(), 0);
      o_ready = 1'b1;

      // Flush with two beats in flight
      drive(1'b1, 32'h12345678, 5'd8, 1'b0, 1'b1); tick();
      drive(1'b1, 32'h9ABCDEF0, 5'd3, 1'b1, 1'b1); tick();
      drive(1'b1, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b1);
      i_flush = 1'b1;
      #1 chk("flush_ready", {31'h0, i_ready}, 32'h0);
      tick();
      i_flush = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      chk("flush_o_valid", {31'h0, o_valid}, 32'h0);
      chk("flush_o_busy", {31'h0, o_busy}, 32'h0);
      drive(1'b1, 32'hCAFEF00D, 5'd12, 1'b1, 1'b1); tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0); tick();
      chk("post_flush_valid", {31'h0, o_valid}, 32'h1);
      chk("post_flush_data", {16'h0, o_data_bus}, {16'h0, ref_sel(32'hCAFEF00D, 5'd12, 1'b1, 1'b1)});
      tick();

      // Asynchronous reset mid-cycle with two beats stalled
      o_ready = 1'b0;
      drive(1'b1, 32'h0F0F0F0F, 5'd1, 1'b0, 1'b1); tick();
      drive(1'b1, 32'hF0F0F0F0, 5'd2, 1'b0, 1'b1); tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1;
      chk("arst_o_valid", {31'h0, o_valid}, 32'h0);
      chk("arst_o_busy", {31'h0, o_busy}, 32'h0);
      chk("arst_o_data", {16'h0, o_data_bus}, 32'h0);
      sb.delete();
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      o_ready = 1'b1;
      #1 chk("arst_rel_ready", {31'h0, i_ready}, 32'h1);
      @(negedge clk);
      drive(1'b1, 32'hDEADBEEF, 5'd20, 1'b1, 1'b1); tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0); tick();
      chk("post_arst_valid", {31'h0, o_valid}, 32'h1);
      chk("post_arst_data", {16'h0, o_data_bus}, {16'h0, ref_sel(32'hDEADBEEF, 5'd20, 1'b1, 1'b1)});
      tick();

      // Randomized stream against the scoreboard
      for (int j = 0; j < 400; j++) begin
         drive(1'($urandom), $urandom, 5'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0));
         o_ready = ($urandom_range(0, 3) != 0);
         i_flush = ($urandom_range(0, 31) == 0);
         tick();
      end
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      i_flush = 1'b0;
      o_ready = 1'b1;
      for (int j = 0; j < 10 && sb.size() != 0; j++) tick();
      chk("final_drain", sb.size(), 0);
      chk("final_idle", {31'h0, o_busy}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
